usart_transceiver: RTL and testbench
====================================

Name: usart_transceiver

Overview:
Byte-wide asynchronous serial (8N1) transmitter and receiver pair, both timed by one programmable bit period in clock cycles.
- TX serialises a byte on request.
- RX deserialises a byte from an independent input line.
- A loopback (tx_pin tied to rx_pin outside the block) is the standard self-test configuration.
- Status flags are active-low "busy": high = idle/done, low = working.

Parameters:
- DATA_W, 8, data bits per frame (fixed 8; LSB sent first).
- PRESC_W, 16, width of the prescaler input.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- prescaler  in  PRESC_W  clocks per bit (1250 nominal); latched at each frame start.
- tx_data  in  8  byte to send; latched when a frame starts.
- transmit  in  1  active-low send request, level-sensitive.
- tx_pin  out  1  serial output, idle high.
- tx_busy_n  out  1  0 while a TX frame is in progress, 1 when idle.
- rx_pin  in  1  serial input, asynchronous to clock.
- rx_data  out  8  last correctly received byte.
- rx_busy_n  out  1  0 while receiving, 1 when idle; rising edge marks completion.
- rx_frame_err  out  1  one-cycle pulse when the stop bit is sampled low.

Behaviour:
- Reset (reset=0, async): tx_pin=1, tx_busy_n=1, rx_busy_n=1, rx_data=0, rx_frame_err=0; both FSMs go to IDLE; counters cleared.
- Bit period P = latched prescaler. Values below 4 are clamped to 4.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if transmit=0 on a clock edge, latch tx_data and P, then go to START.
  - On that same edge, tx_pin←0 and tx_busy_n←0.
  - START: line low for P cycles.
  - DATA: bits 0..7, LSB first, P cycles each.
  - STOP: line high for P cycles, then tx_busy_n←1 and return to IDLE.
  - Frame length is exactly 10·P cycles.
  - If transmit is still 0 when back in IDLE, the next frame starts on the following edge (one idle-high cycle between frames).
  - Changes to tx_data or transmit mid-frame are ignored.
- RX FSM states: IDLE, START, DATA, STOP.
  - rx_pin passes through a 2-flop synchroniser before any use.
  - IDLE: synchronised line =0 → latch P, rx_busy_n←0, go to START.
  - START: wait P/2 (integer floor), then resample.
    - If the line is 1, this is a false start: return to IDLE, set rx_busy_n←1, leave rx_data unchanged, assert no error.
  - DATA: sample every P cycles at bit centres; shift in LSB first into an internal register.
  - STOP: sample after a further P cycles.
    - If 1: rx_data←shift register.
    - If 0: rx_data is unchanged and rx_frame_err pulses for one cycle.
  - The FSM then waits until the line is high before going to IDLE.
  - rx_busy_n rises one cycle after rx_data is written, so rx_data is stable at and after the rx_busy_n rising edge.
  - Completion latency: rx_busy_n rises ≈9.5·P+3 cycles after the start-bit falling edge on rx_pin.
- TX and RX are fully independent and may operate simultaneously.
- A change of prescaler mid-frame takes effect at the next frame only.

Decomposition:
- Package usart_pkg holds:
  - DATA_W and PRESC_W constants;
  - the state enum (IDLE, START, DATA, STOP) shared by both FSMs;
  - the minimum-prescaler constant (4).
- Two sub-modules: usart_tx_core and usart_rx_core.
  - Each has its own bit counter, bit index and FSM.
  - The top level only wires them together.

Test Plan:
- Loopback, P=1250, tx_data=0x14, transmit pulsed low:
  - tx_busy_n is low for exactly 12500 cycles;
  - rx_busy_n rises afterwards with rx_data=0x14.
- P=16, tx_data=0xA5: tx_pin per 16-cycle slot = 0,1,0,1,0,0,1,0,1,1, then idles high.
- rx_pin low pulse of 3 cycles with P=16:
  - rx_busy_n dips then returns to 1 within ~12 cycles;
  - rx_data and rx_frame_err are unchanged.
- Driven frame 0x3C with stop bit 0, P=16:
  - rx_frame_err pulses once;
  - rx_data keeps its previous value.
- transmit held low for 3 frames, P=8, data 0x01/0x02/0x03 (tx_data changed while tx_busy_n=0): three frames back-to-back, one idle cycle apart, carrying each latched byte.
- reset asserted mid-TX and mid-RX frame:
  - outputs immediately go to their reset values;
  - after release, the next 0x55 loopback frame is received correctly.

Source files
------------

// File: rtl/usart_pkg.sv
// rtl/usart_pkg.sv - shared constants, FSM state type and prescaler clamp for the 8N1 USART
package usart_pkg;

    localparam int DATA_W  = 8;
    localparam int PRESC_W = 16;
    localparam int BIT_W   = $clog2(DATA_W);

    localparam logic [PRESC_W-1:0] MIN_PRESC = PRESC_W'(4);
    localparam logic [BIT_W-1:0]   LAST_BIT  = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } usart_state_t;

    function automatic logic [PRESC_W-1:0] clamp_presc(input logic [PRESC_W-1:0] p);
        return (p < MIN_PRESC) ? MIN_PRESC : p;
    endfunction

endpackage

// File: rtl/usart_rx_core.sv
// rtl/usart_rx_core.sv - 8N1 deserialiser with start validation and stop-bit framing check
module usart_rx_core
    import usart_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [PRESC_W-1:0] prescaler,
    input  logic               rx_pin,
    output logic [DATA_W-1:0]  rx_data,
    output logic               rx_busy_n,
    output logic               rx_frame_err
);

    usart_state_t       state;
    logic               sync_1;
    logic               sync_2;
    logic [PRESC_W-1:0] p_lat;
    logic [PRESC_W-1:0] cnt;
    logic [BIT_W-1:0]   bit_idx;
    logic [DATA_W-1:0]  shreg;
    logic               stop_done;
    logic               bit_end;
    logic               half_end;

    assign bit_end  = (cnt == p_lat - PRESC_W'(1));
    assign half_end = (cnt == (p_lat >> 1) - PRESC_W'(1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_1       <= 1'b1;
            sync_2       <= 1'b1;
            state        <= ST_IDLE;
            p_lat        <= MIN_PRESC;
            cnt          <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            stop_done    <= 1'b0;
            rx_data      <= '0;
            rx_busy_n    <= 1'b1;
            rx_frame_err <= 1'b0;
        end else begin
            sync_1       <= rx_pin;
            sync_2       <= sync_1;
            rx_frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!sync_2) begin
                        p_lat     <= clamp_presc(prescaler);
                        cnt       <= '0;
                        rx_busy_n <= 1'b0;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (half_end) begin
                        cnt <= '0;
                        if (sync_2) begin
                            rx_busy_n <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            bit_idx <= '0;
                            state   <= ST_DATA;
                        end
                    end else begin
                        cnt <= cnt + PRESC_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        shreg <= {sync_2, shreg[DATA_W-1:1]};
                        if (bit_idx == LAST_BIT) begin
                            stop_done <= 1'b0;
                            state     <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                        end
                    end else begin
                        cnt <= cnt + PRESC_W'(1);
                    end
                end
                ST_STOP: begin
                    // after the stop sample, linger until the line is idle so a held break is not a new start
                    if (stop_done) begin
                        if (sync_2) begin
                            rx_busy_n <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end else if (bit_end) begin
                        cnt       <= '0;
                        stop_done <= 1'b1;
                        if (sync_2) begin
                            rx_data <= shreg;
                        end else begin
                            rx_frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + PRESC_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/usart_tx_core.sv
// rtl/usart_tx_core.sv - 8N1 serialiser, LSB first, one latched bit period per frame
module usart_tx_core
    import usart_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [PRESC_W-1:0] prescaler,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               transmit,
    output logic               tx_pin,
    output logic               tx_busy_n
);

    usart_state_t       state;
    logic [PRESC_W-1:0] p_lat;
    logic [PRESC_W-1:0] cnt;
    logic [BIT_W-1:0]   bit_idx;
    logic [DATA_W-1:0]  shreg;
    logic               bit_end;

    assign bit_end = (cnt == p_lat - PRESC_W'(1));

    // tx_pin is registered so each line level holds exactly P cycles from the edge that set it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            p_lat     <= MIN_PRESC;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            tx_pin    <= 1'b1;
            tx_busy_n <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!transmit) begin
                        shreg     <= tx_data;
                        p_lat     <= clamp_presc(prescaler);
                        cnt       <= '0;
                        tx_pin    <= 1'b0;
                        tx_busy_n <= 1'b0;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        tx_pin  <= shreg[0];
                        state   <= ST_DATA;
                    end else begin
                        cnt <= cnt + PRESC_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bit_idx == LAST_BIT) begin
                            tx_pin <= 1'b1;
                            state  <= ST_STOP;
                        end else begin
                            shreg   <= {1'b0, shreg[DATA_W-1:1]};
                            tx_pin  <= shreg[1];
                            bit_idx <= bit_idx + BIT_W'(1);
                        end
                    end else begin
                        cnt <= cnt + PRESC_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        cnt       <= '0;
                        tx_busy_n <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        cnt <= cnt + PRESC_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/usart_transceiver.sv
// rtl/usart_transceiver.sv - independent 8N1 transmitter and receiver sharing one prescaler input
module usart_transceiver
    import usart_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [PRESC_W-1:0] prescaler,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               transmit,
    output logic               tx_pin,
    output logic               tx_busy_n,
    input  logic               rx_pin,
    output logic [DATA_W-1:0]  rx_data,
    output logic               rx_busy_n,
    output logic               rx_frame_err
);

    usart_tx_core u_tx (
        .clock     (clock),
        .reset     (reset),
        .prescaler (prescaler),
        .tx_data   (tx_data),
        .transmit  (transmit),
        .tx_pin    (tx_pin),
        .tx_busy_n (tx_busy_n)
    );

    usart_rx_core u_rx (
        .clock        (clock),
        .reset        (reset),
        .prescaler    (prescaler),
        .rx_pin       (rx_pin),
        .rx_data      (rx_data),
        .rx_busy_n    (rx_busy_n),
        .rx_frame_err (rx_frame_err)
    );

endmodule

// File: tb/tb_usart_transceiver.sv
// tb/tb_usart_transceiver.sv - directed self-checking bench for usart_transceiver
module tb_usart_transceiver;

    logic        clock;
    logic        reset;
    logic [15:0] prescaler;
    logic [7:0]  tx_data;
    logic        transmit;
    logic        tx_pin;
    logic        tx_busy_n;
    logic        rx_line;
    logic [7:0]  rx_data;
    logic        rx_busy_n;
    logic        rx_frame_err;

    logic        loop_en;
    logic        rx_drv;
    logic        rx_prev;
    logic [7:0]  rxq[$];
    int          err_cnt;
    int          checks;
    int          failures;

    assign rx_line = loop_en ? tx_pin : rx_drv;

    usart_transceiver dut (
        .clock        (clock),
        .reset        (reset),
        .prescaler    (prescaler),
        .tx_data      (tx_data),
        .transmit     (transmit),
        .tx_pin       (tx_pin),
        .tx_busy_n    (tx_busy_n),
        .rx_pin       (rx_line),
        .rx_data      (rx_data),
        .rx_busy_n    (rx_busy_n),
        .rx_frame_err (rx_frame_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        rx_prev <= rx_busy_n;
        if (rx_busy_n && !rx_prev) rxq.push_back(rx_data);
        if (rx_frame_err) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rx(input int n);
        int t = 0;
        while (rxq.size() < n && t < 20000) begin
            t++;
            @(negedge clock);
        end
    endtask

    task automatic wait_tx_idle();
        int t = 0;
        while (!tx_busy_n && t < 20000) begin
            t++;
            @(negedge clock);
        end
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
        rx_drv = 1'b0;
        repeat (16) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (16) @(negedge clock);
        end
        rx_drv = stop_bit;
        repeat (16) @(negedge clock);
        rx_drv = 1'b1;
    endtask

    initial begin
        int          n;
        int          g;
        int          e0;
        logic        dipped;
        logic [9:0]  exp_frame;

        checks    = 0;
        failures  = 0;
        err_cnt   = 0;
        rx_prev   = 1'b1;
        reset     = 1'b0;
        prescaler = 16'd1250;
        tx_data   = 8'h00;
        transmit  = 1'b1;
        loop_en   = 1'b1;
        rx_drv    = 1'b1;

        repeat (3) @(negedge clock);
        check("rst_tx_pin", tx_pin, 1);
        check("rst_tx_busy_n", tx_busy_n, 1);
        check("rst_rx_busy_n", rx_busy_n, 1);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_frame_err", rx_frame_err, 0);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // loopback at nominal P=1250
        rxq.delete();
        tx_data  = 8'h14;
        transmit = 1'b0;
        @(negedge clock);
        transmit = 1'b1;
        n = 0;
        while (!tx_busy_n && n < 20000) begin
            n++;
            @(negedge clock);
        end
        check("p1250_busy_len", n, 12500);
        wait_rx(1);
        check("p1250_rx_count", rxq.size(), 1);
        check("p1250_rx_byte", rxq.size() > 0 ? rxq[0] : 8'hxx, 8'h14);
        check("p1250_rx_data", rx_data, 8'h14);

        // slot-by-slot waveform of 0xA5 at P=16
        repeat (5) @(negedge clock);
        rxq.delete();
        prescaler = 16'd16;
        tx_data   = 8'hA5;
        exp_frame = {1'b1, 8'hA5, 1'b0};
        transmit  = 1'b0;
        @(negedge clock);
        transmit = 1'b1;
        tx_data  = 8'h00;
        repeat (8) @(negedge clock);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("a5_slot%0d", k), tx_pin, exp_frame[k]);
            if (k < 9) repeat (16) @(negedge clock);
        end
        repeat (16) @(negedge clock);
        check("a5_idle_pin", tx_pin, 1);
        check("a5_idle_busy", tx_busy_n, 1);
        wait_rx(1);
        check("a5_rx_data", rx_data, 8'hA5);

        // 3-cycle glitch must be rejected as a false start
        repeat (5) @(negedge clock);
        loop_en = 1'b0;
        e0      = err_cnt;
        dipped  = 1'b0;
        rx_drv  = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (!rx_busy_n) dipped = 1'b1;
        end
        rx_drv = 1'b1;
        n = 0;
        while (n < 40 && !(dipped && rx_busy_n)) begin
            if (!rx_busy_n) dipped = 1'b1;
            n++;
            @(negedge clock);
        end
        check("false_dipped", dipped, 1);
        check("false_returned", rx_busy_n, 1);
        check("false_quick", n <= 12, 1);
        check("false_rx_data", rx_data, 8'hA5);
        repeat (3) @(negedge clock);
        check("false_no_err", err_cnt - e0, 0);

        // framing error on 0x3C, then a good 0x3C
        rxq.delete();
        e0 = err_cnt;
        drive_frame(8'h3C, 1'b0);
        wait_rx(1);
        repeat (2) @(negedge clock);
        check("ferr_pulses", err_cnt - e0, 1);
        check("ferr_rx_kept", rx_data, 8'hA5);
        check("ferr_idle", rx_busy_n, 1);
        repeat (4) @(negedge clock);
        rxq.delete();
        e0 = err_cnt;
        drive_frame(8'h3C, 1'b1);
        wait_rx(1);
        check("good_rx_data", rx_data, 8'h3C);
        check("good_no_err", err_cnt - e0, 0);

        // three back-to-back frames at P=8, data updated mid-frame
        repeat (5) @(negedge clock);
        loop_en   = 1'b1;
        rxq.delete();
        prescaler = 16'd8;
        tx_data   = 8'h01;
        transmit  = 1'b0;
        @(negedge clock);
        check("b2b_started", tx_busy_n, 0);
        tx_data = 8'h02;
        for (int f = 0; f < 2; f++) begin
            wait_tx_idle();
            g = 0;
            while (tx_busy_n && g < 100) begin
                g++;
                @(negedge clock);
            end
            check($sformatf("b2b_gap%0d", f), g, 1);
            if (f == 0) tx_data = 8'h03;
        end
        transmit = 1'b1;
        wait_tx_idle();
        repeat (5) @(negedge clock);
        check("b2b_stays_idle", tx_busy_n, 1);
        wait_rx(3);
        check("b2b_count", rxq.size(), 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("b2b_byte%0d", i), rxq.size() > i ? rxq[i] : 8'hxx, i + 1);

        // reset mid-frame on both TX and RX, then recover
        prescaler = 16'd16;
        tx_data   = 8'hF0;
        transmit  = 1'b0;
        @(negedge clock);
        transmit = 1'b1;
        repeat (60) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("midrst_tx_pin", tx_pin, 1);
        check("midrst_tx_busy_n", tx_busy_n, 1);
        check("midrst_rx_busy_n", rx_busy_n, 1);
        check("midrst_rx_data", rx_data, 8'h00);
        check("midrst_rx_frame_err", rx_frame_err, 0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        rxq.delete();
        e0       = err_cnt;
        tx_data  = 8'h55;
        transmit = 1'b0;
        @(negedge clock);
        transmit = 1'b1;
        wait_rx(1);
        check("postrst_count", rxq.size(), 1);
        check("postrst_rx_data", rx_data, 8'h55);
        check("postrst_no_err", err_cnt - e0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
